emblem_overlay_ctrl: RTL and testbench

Sequences the crest emblem overlay on the 640x480 VGA output. A frame-synchronous FSM fades the emblem in on a trigger, holds it, then fades it out. The block drives the emblem generator's active input, keys out its transparent colour, dims its colour by the fade level and muxes it over the background. It sits between the emblem generator, the background pattern source and the output register stage.

---
 rtl/emblem_overlay_ctrl.sv | 169 ++++++++++++++++
 tb/tb_emblem_overlay_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emblem_overlay_ctrl.sv
// Crest emblem overlay sequencer for 640x480 VGA.
// A frame-synchronous FSM fades the emblem in on a trigger, holds it at full
// brightness and fades it out again. The pixel path keys out the transparent
// colour, dims the emblem by the current fade level and registers the
// composite over the background.
module emblem_overlay_ctrl #(
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter logic [5:0]  COLOR_KEY   = 6'b100001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       trigger,
  input  logic       enable,
  input  logic       video_active,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [5:0] bg_rgb,
  input  logic [5:0] emblem_rgb,
  output logic       emblem_active,
  output logic [5:0] rgb_out,
  output logic [1:0] state,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFadeIn  = 2'd1,
    StHold    = 2'd2,
    StFadeOut = 2'd3
  } state_e;

  localparam logic [7:0] StepLast = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] HoldLast = 8'(HOLD_FRAMES - 1);
  localparam logic [1:0] LevelMax = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic [5:0] rgb_q, rgb_d;

  logic       pend_now;
  logic       consume;
  logic [1:0] level_up;
  logic [5:0] faded;

  // Position is only meaningful to the emblem generator, not to this block.
  logic unused_pos;
  assign unused_pos = ^{x, y};

  // A trigger in the same cycle as frame_start is honoured at that frame.
  assign pend_now = pending_q | (trigger & enable);
  assign level_up = (level_q == LevelMax) ? LevelMax : level_q + 2'd1;

  // State, level, frame counter, pending request and composited pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      level_q   <= 2'd0;
      cnt_q     <= 8'd0;
      pending_q <= 1'b0;
      rgb_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      rgb_q     <= rgb_d;
    end
  end

  // Next-state logic; sequencing only advances on frame_start to avoid tearing.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    if (frame_start) begin
      unique case (state_q)
        StIdle: begin
          if (pend_now && enable) begin
            state_d = StFadeIn;
            level_d = 2'd0;
            cnt_d   = 8'd0;
            consume = 1'b1;
          end
        end
        StFadeIn: begin
          if (!enable) begin
            state_d = StFadeOut;
            cnt_d   = 8'd0;
          end else if (cnt_q == StepLast) begin
            cnt_d   = 8'd0;
            level_d = level_up;
            if (level_up == LevelMax) state_d = StHold;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (!enable) begin
            state_d = StFadeOut;
            cnt_d   = 8'd0;
          end else if (pend_now) begin
            // Retrigger restarts the hold period.
            cnt_d   = 8'd0;
            consume = 1'b1;
          end else if (cnt_q == HoldLast) begin
            state_d = StFadeOut;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StFadeOut: begin
          if (pend_now && enable) begin
            // Fade back in from wherever the level currently is.
            state_d = StFadeIn;
            cnt_d   = 8'd0;
            consume = 1'b1;
          end else if (level_q == 2'd0) begin
            // Reached when enable drops during FADE_IN at level 0.
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else if (cnt_q == StepLast) begin
            cnt_d   = 8'd0;
            level_d = level_q - 2'd1;
            if (level_q == 2'd1) state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pending request: latched while enabled, dropped on consume or disable.
  always_comb begin
    pending_d = pending_q;
    if (!enable || consume) begin
      pending_d = 1'b0;
    end else if (trigger) begin
      pending_d = 1'b1;
    end
  end

  // Outputs and next composited pixel.
  always_comb begin
    busy          = (state_q != StIdle);
    emblem_active = video_active & busy;
    for (int i = 0; i < 3; i++) begin
      faded[2*i +: 2] = (emblem_rgb[2*i +: 2] < level_q) ? emblem_rgb[2*i +: 2] : level_q;
    end
    if (!video_active) begin
      rgb_d = 6'd0;
    end else if (emblem_active && (emblem_rgb != COLOR_KEY) && (level_q != 2'd0)) begin
      rgb_d = faded;
    end else begin
      rgb_d = bg_rgb;
    end
  end

  assign state   = state_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_emblem_overlay_ctrl.sv
// Self-checking bench for emblem_overlay_ctrl with short fade/hold timing.
module tb_emblem_overlay_ctrl;

  localparam int unsigned Step = 2;
  localparam int unsigned Hold = 3;
  localparam logic [5:0]  Key  = 6'b100001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       trigger = 1'b0;
  logic       enable = 1'b1;
  logic       video_active = 1'b1;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic [5:0] bg_rgb = 6'd0;
  logic [5:0] emblem_rgb = 6'b111111;
  logic       emblem_active;
  logic [5:0] rgb_out;
  logic [1:0] state;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  emblem_overlay_ctrl #(
    .STEP_FRAMES(Step),
    .HOLD_FRAMES(Hold),
    .COLOR_KEY  (Key)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .trigger      (trigger),
    .enable       (enable),
    .video_active (video_active),
    .x            (x),
    .y            (y),
    .bg_rgb       (bg_rgb),
    .emblem_rgb   (emblem_rgb),
    .emblem_active(emblem_active),
    .rgb_out      (rgb_out),
    .state        (state),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 brightening, 2 holding, 3 dimming.
  int         m_phase = 0;
  int         m_lvl = 0;
  int         m_frames = 0;
  bit         m_req = 0;
  logic [5:0] m_rgb = 6'd0;

  function automatic logic [5:0] dim(input logic [5:0] c, input int lvl);
    logic [5:0] r;
    for (int i = 0; i < 3; i++) begin
      int ch;
      ch = int'(c[2*i +: 2]);
      r[2*i +: 2] = 2'((ch < lvl) ? ch : lvl);
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_lvl    <= 0;
      m_frames <= 0;
      m_req    <= 0;
      m_rgb    <= 6'd0;
    end else begin
      int  ph, lv, fr;
      bit  want, took;
      ph = m_phase; lv = m_lvl; fr = m_frames;
      want = m_req || (trigger && enable);
      took = 0;
      if (!video_active) m_rgb <= 6'd0;
      else if (m_phase != 0 && emblem_rgb != Key && m_lvl != 0) m_rgb <= dim(emblem_rgb, m_lvl);
      else m_rgb <= bg_rgb;
      if (frame_start) begin
        if (m_phase == 0) begin
          if (want && enable) begin ph = 1; lv = 0; fr = 0; took = 1; end
        end else if (m_phase == 1) begin
          if (!enable) begin ph = 3; fr = 0; end
          else if (m_frames + 1 == Step) begin
            fr = 0; lv = (m_lvl + 1 > 3) ? 3 : m_lvl + 1;
            if (lv == 3) ph = 2;
          end else fr = m_frames + 1;
        end else if (m_phase == 2) begin
          if (!enable) begin ph = 3; fr = 0; end
          else if (want) begin fr = 0; took = 1; end
          else if (m_frames + 1 == Hold) begin ph = 3; fr = 0; end
          else fr = m_frames + 1;
        end else begin
          if (want && enable) begin ph = 1; fr = 0; took = 1; end
          else if (m_lvl == 0) begin ph = 0; fr = 0; end
          else if (m_frames + 1 == Step) begin
            fr = 0; lv = m_lvl - 1;
            if (lv == 0) ph = 0;
          end else fr = m_frames + 1;
        end
      end
      m_phase  <= ph;
      m_lvl    <= lv;
      m_frames <= fr;
      m_req    <= enable && !took && (m_req || trigger);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] es;
    es = 2'(m_phase);
    vectors++;
    if (state !== es || busy !== (m_phase != 0) ||
        emblem_active !== (video_active && m_phase != 0) || rgb_out !== m_rgb) begin
      errors++;
      $display("FAIL model t=%0t state=%0d/%0d busy=%b ea=%b rgb=%b / want rgb=%b",
               $time, state, es, busy, emblem_active, rgb_out, m_rgb);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic pin(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic colour(input string name, input logic [5:0] em, input logic [5:0] bg,
                        input logic [5:0] exp);
    emblem_rgb = em;
    bg_rgb     = bg;
    step();
    step();
    pin(name, {2'b0, rgb_out}, {2'b0, exp});
    emblem_rgb = 6'b111111;
    bg_rgb     = 6'd0;
    step();
  endtask

  int st_tab[16] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 0};
  int lv_tab[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};

  initial begin
    logic [1:0] lv;
    repeat (3) step();
    rst = 1'b0;
    step();
    pin("idle_state", {6'b0, state}, 8'd0);
    pin("idle_busy", {7'b0, busy}, 8'd0);

    // Full sequence; white emblem over black shows the level on every channel.
    pulse_trig();
    for (int k = 0; k < 16; k++) begin
      fs();
      lv = 2'(lv_tab[k]);
      pin($sformatf("seq%0d_state", k + 1), {6'b0, state}, 8'(st_tab[k]));
      pin($sformatf("seq%0d_rgb", k + 1), {2'b0, rgb_out}, {2'b0, lv, lv, lv});
      if (k == 2) begin
        colour("gold_l1", 6'b110110, 6'd0, 6'b010101);
        colour("red_l1", 6'b100100, 6'd0, 6'b010100);
      end
      if (k == 4) colour("gold_l2", 6'b110110, 6'd0, 6'b100110);
      if (k == 6) begin
        colour("gold_l3", 6'b110110, 6'd0, 6'b110110);
        colour("key_l3", Key, 6'b001100, 6'b001100);
        video_active = 1'b0;
        step();
        step();
        pin("blank_rgb", {2'b0, rgb_out}, 8'd0);
        pin("blank_ea", {7'b0, emblem_active}, 8'd0);
        video_active = 1'b1;
        step();
      end
    end

    // Trigger coincident with frame_start starts at that same frame.
    trigger = 1'b1;
    frame_start = 1'b1;
    step();
    trigger = 1'b0;
    frame_start = 1'b0;
    step();
    pin("coinc_state", {6'b0, state}, 8'd1);
    repeat (6) fs();
    pin("hold_state", {6'b0, state}, 8'd2);
    fs();
    fs();
    // Hold counter now at 2: retrigger restarts the hold.
    pulse_trig();
    fs();
    fs();
    fs();
    pin("hold_ext", {6'b0, state}, 8'd2);
    fs();
    pin("hold_end", {6'b0, state}, 8'd3);
    fs();
    fs();
    pin("fo_l2_rgb", {2'b0, rgb_out}, 8'b00101010);
    pulse_trig();
    fs();
    pin("refade_state", {6'b0, state}, 8'd1);
    pin("refade_rgb", {2'b0, rgb_out}, 8'b00101010);
    fs();
    fs();
    pin("rehold_state", {6'b0, state}, 8'd2);

    // Dropping enable in HOLD forces a fade-out down to idle.
    enable = 1'b0;
    step();
    fs();
    pin("dis_fo", {6'b0, state}, 8'd3);
    repeat (6) fs();
    pin("dis_idle", {6'b0, state}, 8'd0);
    pulse_trig();
    for (int k = 0; k < 4; k++) begin
      fs();
      pin($sformatf("dis_trig%0d", k), {6'b0, state}, 8'd0);
    end
    enable = 1'b1;
    fs();
    pin("en_no_pend", {6'b0, state}, 8'd0);

    // Reset asserted mid-HOLD clears everything immediately.
    pulse_trig();
    repeat (7) fs();
    pin("pre_rst_state", {6'b0, state}, 8'd2);
    pin("pre_rst_rgb", {2'b0, rgb_out}, 8'b00111111);
    rst = 1'b1;
    #1;
    pin("rst_rgb", {2'b0, rgb_out}, 8'd0);
    pin("rst_state", {6'b0, state}, 8'd0);
    pin("rst_busy", {7'b0, busy}, 8'd0);
    bg_rgb = 6'b000011;
    step();
    step();
    pin("rst_hold_rgb", {2'b0, rgb_out}, 8'd0);
    rst = 1'b0;
    step();
    pin("post_rst_rgb", {2'b0, rgb_out}, 8'b00000011);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
